// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo
// Packet-aware output FIFO for one router destination channel. Each stored
// entry is {hdr, data}; the read side tracks how many bytes remain in the
// packet being drained (taken from the header's length field) and flags the
// last (parity) byte of every packet.
//
// Ports
//   clk          rising-edge clock
//   resetn       synchronous active-low reset
//   soft_reset   synchronous flush, active-high (read-timeout recovery)
//   write_enb    write request
//   lfd_state    datain is a packet header this cycle
//   datain       write data [DW-1:0]
//   read_enb     read request
//   dataout      registered read data, holds until the next pop
//   rd_valid     dataout was popped on the previous edge
//   rd_last      dataout is the final byte of its packet
//   full/empty   occupancy decodes (state before the current edge)
//   almost_full  occupancy >= DEPTH - AF_MARGIN
//   occupancy    number of stored entries [AW:0]
//   overflow     one-cycle pulse after a write attempted while full
module router_pkt_fifo #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          soft_reset,
    input  logic          write_enb,
    input  logic          lfd_state,
    input  logic [DW-1:0] datain,
    input  logic          read_enb,
    output logic [DW-1:0] dataout,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   occupancy,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_AF   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [DW-2:0] REM_ONE  = (DW-1)'(1);

    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] write_ptr;
    logic [AW-1:0] read_ptr;
    logic [DW-2:0] pkt_rem;
    logic          wr_ok;
    logic          rd_ok;
    logic [DW:0]   rd_entry;
    logic          rd_hdr;
    logic          run;

    // Flags decode the registered occupancy, so a same-cycle read never
    // makes room for a write and a same-cycle write never feeds a read.
    assign full        = (occupancy == OCC_FULL);
    assign empty       = (occupancy == '0);
    assign almost_full = (occupancy >= OCC_AF);

    assign run      = resetn && !soft_reset;
    assign wr_ok    = write_enb && !full;
    assign rd_ok    = read_enb && !empty;
    assign rd_entry = mem[read_ptr];
    assign rd_hdr   = rd_entry[DW];

    // Storage is not reset; stale contents are never observable because
    // the pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (run && wr_ok)
            mem[write_ptr] <= {lfd_state, datain};
    end

    always_ff @(posedge clk) begin
        if (!resetn || soft_reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            occupancy <= '0;
            pkt_rem   <= '0;
            dataout   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= write_enb && full;
            rd_valid <= rd_ok;
            rd_last  <= rd_ok && !rd_hdr && (pkt_rem == REM_ONE);

            if (wr_ok)
                write_ptr <= write_ptr + PTR_ONE;

            if (rd_ok) begin
                read_ptr <= read_ptr + PTR_ONE;
                dataout  <= rd_entry[DW-1:0];
                // Header loads payload length plus one for the parity byte;
                // a stray non-header byte with nothing pending leaves it at 0.
                if (rd_hdr)
                    pkt_rem <= {1'b0, rd_entry[DW-1:2]} + REM_ONE;
                else if (pkt_rem != '0)
                    pkt_rem <= pkt_rem - REM_ONE;
            end

            case ({wr_ok, rd_ok})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
module tb_router_pkt_fifo;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] datain = '0;
    logic       read_enb = 1'b0;
    logic [7:0] dataout;
    logic       rd_valid, rd_last, full, empty, almost_full, overflow;
    logic [4:0] occupancy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    router_pkt_fifo #(.DW(8), .AW(4), .AF_MARGIN(2)) dut (
        .clk(clk), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .lfd_state(lfd_state), .datain(datain),
        .read_enb(read_enb), .dataout(dataout), .rd_valid(rd_valid),
        .rd_last(rd_last), .full(full), .empty(empty),
        .almost_full(almost_full), .occupancy(occupancy), .overflow(overflow)
    );

    typedef struct {
        logic       rn, sr, we, lfd;
        logic [7:0] din;
        logic       re;
        logic [7:0] e_do;
        logic       e_vld, e_last, e_empty, e_full, e_ovf;
        logic [4:0] e_occ;
    } vec_t;

    function automatic vec_t mk(input logic rn, sr, we, lfd, input logic [7:0] din,
                                input logic re, input logic [7:0] e_do,
                                input logic e_vld, e_last, e_empty, e_full, e_ovf,
                                input logic [4:0] e_occ);
        vec_t v;
        v.rn = rn; v.sr = sr; v.we = we; v.lfd = lfd; v.din = din; v.re = re;
        v.e_do = e_do; v.e_vld = e_vld; v.e_last = e_last; v.e_empty = e_empty;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic rn, sr, we, lfd, input logic [7:0] din, input logic re);
        resetn = rn; soft_reset = sr; write_enb = we; lfd_state = lfd;
        datain = din; read_enb = re;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        cyc(1, 0, 1, lfd, d, 0);
    endtask

    task automatic rd();
        cyc(1, 0, 0, 0, 8'h00, 1);
    endtask

    vec_t vecs[15];
    logic [7:0] q[$];
    logic [7:0] exp_b;

    initial begin
        // rn sr we lfd din re | dout vld last empty full ovf occ
        vecs[0]  = mk(0,0,0,0,8'h00,0, 8'h00,0,0,1,0,0,5'd0);   // reset
        vecs[1]  = mk(1,0,1,1,8'h04,0, 8'h00,0,0,0,0,0,5'd1);   // hdr len 1
        vecs[2]  = mk(1,0,1,0,8'hA5,0, 8'h00,0,0,0,0,0,5'd2);
        vecs[3]  = mk(1,0,1,0,8'h5A,0, 8'h00,0,0,0,0,0,5'd3);   // parity
        vecs[4]  = mk(1,0,0,0,8'h00,1, 8'h04,1,0,0,0,0,5'd2);
        vecs[5]  = mk(1,0,0,0,8'h00,1, 8'hA5,1,0,0,0,0,5'd1);
        vecs[6]  = mk(1,0,0,0,8'h00,1, 8'h5A,1,1,1,0,0,5'd0);   // last
        vecs[7]  = mk(1,0,0,0,8'h00,0, 8'h5A,0,0,1,0,0,5'd0);   // hold
        vecs[8]  = mk(1,0,0,0,8'h00,1, 8'h5A,0,0,1,0,0,5'd0);   // read empty
        vecs[9]  = mk(1,0,1,1,8'h00,0, 8'h5A,0,0,0,0,0,5'd1);   // hdr len 0
        vecs[10] = mk(1,0,1,0,8'h77,0, 8'h5A,0,0,0,0,0,5'd2);
        vecs[11] = mk(1,0,0,0,8'h00,1, 8'h00,1,0,0,0,0,5'd1);
        vecs[12] = mk(1,0,0,0,8'h00,1, 8'h77,1,1,1,0,0,5'd0);   // parity last
        vecs[13] = mk(1,0,1,0,8'h33,0, 8'h77,0,0,0,0,0,5'd1);   // stray byte
        vecs[14] = mk(1,0,0,0,8'h00,1, 8'h33,1,0,1,0,0,5'd0);

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].rn, vecs[i].sr, vecs[i].we, vecs[i].lfd, vecs[i].din, vecs[i].re);
            chk($sformatf("v%0d dataout", i),   dataout,   vecs[i].e_do);
            chk($sformatf("v%0d rd_valid", i),  rd_valid,  vecs[i].e_vld);
            chk($sformatf("v%0d rd_last", i),   rd_last,   vecs[i].e_last);
            chk($sformatf("v%0d empty", i),     empty,     vecs[i].e_empty);
            chk($sformatf("v%0d full", i),      full,      vecs[i].e_full);
            chk($sformatf("v%0d overflow", i),  overflow,  vecs[i].e_ovf);
            chk($sformatf("v%0d occupancy", i), occupancy, vecs[i].e_occ);
        end

        // Fill to full, then overflow.
        cyc(0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            wr(0, 8'h10 + 8'(i));
            chk($sformatf("fill%0d occ", i), occupancy, i + 1);
            chk($sformatf("fill%0d almost_full", i), almost_full, (i + 1 >= 14) ? 1 : 0);
            chk($sformatf("fill%0d full", i), full, (i + 1 == 16) ? 1 : 0);
        end
        wr(0, 8'hEE);
        chk("ovf pulse", overflow, 1);
        chk("ovf occ", occupancy, 16);
        cyc(1, 0, 0, 0, 8'h00, 0);
        chk("ovf clears", overflow, 0);

        // Read+write while full: read wins, write dropped.
        cyc(1, 0, 1, 0, 8'hDD, 1);
        chk("full rw dataout", dataout, 8'h10);
        chk("full rw valid", rd_valid, 1);
        chk("full rw occ", occupancy, 15);
        chk("full rw ovf", overflow, 1);
        wr(0, 8'hDD);
        chk("refill occ", occupancy, 16);
        for (int i = 0; i < 16; i++) begin
            rd();
            exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'hDD;
            chk($sformatf("drain%0d data", i), dataout, exp_b);
            chk($sformatf("drain%0d last", i), rd_last, 0);
        end
        chk("drain empty", empty, 1);

        // Wrap-around with simultaneous traffic at occupancy 8.
        cyc(0, 0, 0, 0, 8'h00, 0);
        q.delete();
        for (int i = 0; i < 8; i++) begin
            wr(0, 8'h80 + 8'(i));
            q.push_back(8'h80 + 8'(i));
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 1, 0, 8'(i * 7 + 3), 1);
            exp_b = q.pop_front();
            q.push_back(8'(i * 7 + 3));
            chk($sformatf("wrap%0d data", i), dataout, exp_b);
            chk($sformatf("wrap%0d occ", i), occupancy, 8);
        end
        for (int i = 0; i < 8; i++) begin
            rd();
            exp_b = q.pop_front();
            chk($sformatf("wdrain%0d data", i), dataout, exp_b);
        end
        chk("wrap empty", empty, 1);

        // Soft reset mid-packet.
        wr(1, 8'h20);
        for (int i = 0; i < 9; i++) wr(0, 8'hC0 + 8'(i));
        rd();
        rd();
        chk("sr pre data", dataout, 8'hC0);
        cyc(1, 1, 1, 0, 8'h99, 1);
        chk("sr occ", occupancy, 0);
        chk("sr empty", empty, 1);
        chk("sr dataout", dataout, 0);
        chk("sr valid", rd_valid, 0);
        wr(1, 8'h04);
        wr(0, 8'hB1);
        wr(0, 8'hB2);
        rd();
        chk("sr p hdr", dataout, 8'h04);
        chk("sr p hdr last", rd_last, 0);
        rd();
        chk("sr p b1", dataout, 8'hB1);
        chk("sr p b1 last", rd_last, 0);
        rd();
        chk("sr p b2", dataout, 8'hB2);
        chk("sr p b2 last", rd_last, 1);

        // Write and read together on an empty FIFO.
        cyc(1, 0, 1, 1, 8'h08, 1);
        chk("empty rw valid", rd_valid, 0);
        chk("empty rw occ", occupancy, 1);
        wr(0, 8'h42);
        // Reset during traffic.
        cyc(0, 0, 1, 0, 8'h55, 1);
        chk("rst occ", occupancy, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst af", almost_full, 0);
        chk("rst dataout", dataout, 0);
        chk("rst valid", rd_valid, 0);
        chk("rst last", rd_last, 0);
        chk("rst ovf", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware output FIFO for the router's per-destination channels, successor to the fixed 16x8 channel FIFO. It stores each byte with a header marker, tracks the remaining length of the packet being drained from the header's length field, and flags the last byte of every packet on the read side. It adds almost-full, overflow and occupancy reporting, and defined (non-tristate) output values. One instance sits between the router FSM/register write path and each output port's read logic.

## Interface
- DW, 8: data width; header byte carries payload length in bits [DW-1:2].
- AW, 4: address width; depth DEPTH = 2^AW entries.
- AF_MARGIN, 2: almost_full asserts when occupancy >= DEPTH - AF_MARGIN.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- soft_reset  in  1  synchronous flush (read-timeout recovery); active-high.
- write_enb  in  1  write request.
- lfd_state  in  1  same-cycle qualifier: datain is a packet header.
- datain  in  DW  write data.
- read_enb  in  1  read request.
- dataout  out  DW  registered read data.
- rd_valid  out  1  dataout holds a byte popped on the previous edge.
- rd_last  out  1  dataout is the final (parity) byte of a packet.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  see AF_MARGIN.
- occupancy  out  AW+1  entries stored.
- overflow  out  1  one-cycle pulse: write_enb while full.

## Operation
- Storage: DEPTH entries of DW+1 bits, {hdr, data}; hdr = lfd_state at write.
- Write accepted (wr_ok) iff write_enb && !full; entry written at write_ptr, write_ptr += 1 modulo DEPTH (natural AW-bit wrap).
- Read accepted (rd_ok) iff read_enb && !empty; entry at read_ptr popped, read_ptr += 1 modulo DEPTH.
- full/empty/almost_full are combinational decodes of the occupancy register and reflect state before the current edge; a read when full frees space but does not enable a write in the same cycle; a write when empty does not enable a read in the same cycle.
- occupancy: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- overflow = registered (write_enb && full); write is dropped, no state change.
- Packet tracking: pkt_rem register, DW-1 bits. On rd_ok of hdr=1 entry: pkt_rem <= data[DW-1:2] + 1 (payload + parity). On rd_ok of hdr=0 entry with pkt_rem != 0: pkt_rem <= pkt_rem - 1. hdr=0 entry with pkt_rem == 0 (stray byte) still popped, pkt_rem stays 0.
- rd_last <= rd_ok && hdr==0 && pkt_rem==1; otherwise 0.
- rd_valid <= rd_ok. dataout <= popped data on rd_ok, else holds its value (never Z).
- Priority: resetn low > soft_reset > normal operation.
- resetn low: pointers, occupancy, pkt_rem = 0; dataout = 0; rd_valid, rd_last, overflow = 0; hence empty=1, full=0, almost_full=0. Storage contents not cleared (unobservable).
- soft_reset high: same clears as reset, including dataout = 0; concurrent write/read ignored. A packet in flight is discarded; next popped byte must be a header for correct rd_last.

## Timing
- Write-to-flag latency: 1 edge (occupancy updates on the write edge; empty drops in the following cycle).
- Read latency: 1 cycle; read_enb sampled at edge N, dataout/rd_valid/rd_last valid after edge N, held until the next rd_ok.
- Back-to-back reads and writes sustain 1 byte/cycle each.
- Header length 0: header then parity; rd_last on the parity byte.
- Max length field 2^(DW-2)-1: pkt_rem = 2^(DW-2), fits DW-1 bits.

## Test plan
- Reset then write 3-byte packet (hdr 0x04 = len 1, 0xA5, parity 0x5A) and read 3 -> dataout 0x04, 0xA5, 0x5A on consecutive cycles; rd_last only with 0x5A; empty=1 after the last read.
- Fill 16 entries (DW=8, AW=4) -> almost_full at occupancy 14, full at 16; 17th write -> overflow pulse, occupancy stays 16, data unchanged on readback.
- With occupancy 16, assert write and read together -> read succeeds, write dropped, occupancy 15; next cycle write succeeds -> occupancy 16.
- Wrap-around: 40 writes/reads interleaved at occupancy ~8 -> data order preserved across pointer wrap, occupancy never exceeds 16.
- Soft_reset mid-packet (2 of 10 bytes read) -> next cycle occupancy 0, empty=1, dataout 0, rd_valid 0; new packet then reads correctly with rd_last on its parity.
- Read and write when empty in the same cycle -> read ignored (rd_valid 0), occupancy 1; resetn low during traffic -> all outputs at reset values after the edge.
